// File: rtl/cry_pkg.sv
// Shared constants, types and the RGB16 expansion for the CRY/RGB16 converter.
package cry_pkg;

  localparam int ROM_LAT   = 1;
  localparam int NUM_LANES = 3;   // r, g, b
  localparam int VEC_W     = 8;

  // LSB positions of the fields inside a 16-bit pixel
  localparam int CRY_C   = 12;    // [15:12] cyan
  localparam int CRY_R   = 8;     // [11:8]  red
  localparam int CRY_Y   = 0;     // [7:0]   intensity
  localparam int RGB16_R = 11;    // [15:11]
  localparam int RGB16_B = 6;     // [10:6]
  localparam int RGB16_G = 0;     // [5:0]

  typedef struct packed {
    logic [VEC_W-1:0] r;
    logic [VEC_W-1:0] g;
    logic [VEC_W-1:0] b;
  } rgb888_t;

  // Widen 5/6-bit fields by replicating their MSBs into the new LSBs
  function automatic rgb888_t rgb16_expand(input logic [15:0] p);
    rgb888_t    res;
    logic [4:0] r5;
    logic [4:0] b5;
    logic [5:0] g6;
    r5    = p[RGB16_R +: 5];
    b5    = p[RGB16_B +: 5];
    g6    = p[RGB16_G +: 6];
    res.r = {r5, r5[4:2]};
    res.g = {g6, g6[5:4]};
    res.b = {b5, b5[4:2]};
    return res;
  endfunction

endpackage

// File: rtl/cry_scale.sv
// One colour lane: c * (Y+1) >> 8, so Y=00 gives 0 and Y=FF gives c exactly.
module cry_scale
  import cry_pkg::*;
(
  input  logic [VEC_W-1:0] i_c,
  input  logic [VEC_W-1:0] i_y,
  output logic [VEC_W-1:0] o_v
);

  localparam int PW = 2*VEC_W + 1;

  logic [VEC_W:0] w_y1;

  assign w_y1 = {1'b0, i_y} + (VEC_W+1)'(1);
  assign o_v  = VEC_W'((PW'(i_c) * PW'(w_y1)) >> VEC_W);

endmodule

// File: rtl/cry_rgb_conv.sv
// CRY / RGB16 pixel to RGB888 converter: S1 holds the pixel while the colour
// ROMs look it up, S2 holds the result. Valid/ready on both sides, no skid.
module cry_rgb_conv
  import cry_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_pix,
  input  logic        in_rgb16,
  output logic [7:0]  rom_addr,
  input  logic [7:0]  rom_r_z,
  input  logic [7:0]  rom_g_z,
  input  logic [7:0]  rom_b_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b
);

  localparam int STAGES = 2;

  if (ROM_LAT != cry_pkg::ROM_LAT) begin : g_lat_chk
    $error("cry_rgb_conv: only a single-cycle ROM latency is supported");
  end

  logic [STAGES:1]                   r_vld_pipe;  // [1]=S1, [2]=S2/output
  logic [15:0]                       r_s1_pix;
  logic                              r_s1_rgb16;
  rgb888_t                           r_out;
  logic                              w_adv1;
  logic                              w_adv2;
  logic [NUM_LANES-1:0][VEC_W-1:0]   w_rom;
  logic [NUM_LANES-1:0][VEC_W-1:0]   w_cry;
  rgb888_t                           w_res;

  assign w_adv2   = !r_vld_pipe[2] || out_ready;
  assign w_adv1   = !r_vld_pipe[1] || w_adv2;
  assign in_ready = w_adv1;

  // A stalled S1 keeps re-reading its own address so ROM data stays aligned
  assign rom_addr = w_adv1 ? in_pix[15:8]
                           : {r_s1_pix[CRY_C +: 4], r_s1_pix[CRY_R +: 4]};

  assign w_rom = {rom_b_z, rom_g_z, rom_r_z};

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    cry_scale u_scale (
      .i_c (w_rom[gi]),
      .i_y (r_s1_pix[CRY_Y +: VEC_W]),
      .o_v (w_cry[gi])
    );
  end

  // Select the conversion by the mode bit that travelled with the pixel
  always_comb begin
    w_res = rgb16_expand(r_s1_pix);
    if (!r_s1_rgb16) begin
      w_res.r = w_cry[0];
      w_res.g = w_cry[1];
      w_res.b = w_cry[2];
    end
  end

  // Pipeline registers: S1 loads on accept, S2 loads when S1 transfers
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_pipe <= '0;
      r_s1_pix   <= '0;
      r_s1_rgb16 <= 1'b0;
      r_out      <= '0;
    end else begin
      if (w_adv1) begin
        r_vld_pipe[1] <= in_valid;
        if (in_valid) begin
          r_s1_pix   <= in_pix;
          r_s1_rgb16 <= in_rgb16;
        end
      end
      if (w_adv2) begin
        r_vld_pipe[2] <= r_vld_pipe[1];
        if (r_vld_pipe[1]) r_out <= w_res;
      end
    end
  end

  assign out_valid = r_vld_pipe[2];
  assign out_r     = r_out.r;
  assign out_g     = r_out.g;
  assign out_b     = r_out.b;

endmodule
